// File: rtl/i2s_transmitter.sv
// i2s_transmitter: serializes a 32-bit stereo sample word onto a 3-wire I2S-style DAC link.
//
// Ports:
//   MasterCLK      system clock (the only clock domain)
//   Reset          synchronous, active-high reset
//   Enable         level-sensitive run request
//   SampleData     [31:16] left, [15:0] right, two's complement
//   SampleRequest  one-cycle pulse to the synthesizer's OutputDataClock
//   BCLK           bit clock, CLK_DIV cycles low then CLK_DIV cycles high per slot
//   LRCLK          word select, 0 = left, 1 = right
//   SDATA          serial data, MSB first, changes only at slot start
//   Busy           high whenever the transmitter is not idle
//
// Parameter CLK_DIV (2..255): MasterCLK cycles per BCLK half-period.
// Build option I2S_DELAY_EN: Philips I2S timing, LRCLK leads the data by one slot.
// Without it, LRCLK is left-justified (aligned with the data).

module i2s_transmitter #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [31:0] SampleData,
  output logic        SampleRequest,
  output logic        BCLK,
  output logic        LRCLK,
  output logic        SDATA,
  output logic        Busy
);

  localparam logic [8:0] HalfCnt = 9'(CLK_DIV);
  localparam logic [8:0] LastCnt = 9'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPrime = 2'd1,
    StRun   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;     // cycle within slot (RUN) or within the PRIME period
  logic [4:0]  slot_q, slot_d;
  logic [31:0] shift_q, shift_d;
  logic        req_q, req_d;
  logic        bclk_q, bclk_d;
  logic        lrclk_q, lrclk_d;
  logic        sdata_q, sdata_d;
  logic        busy_q, busy_d;
  logic        run_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    shift_d = shift_q;
    req_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Enable) begin
          state_d = StPrime;
          cnt_d   = '0;
          req_d   = 1'b1;
        end
      end
      StPrime: begin
        if (cnt_q == LastCnt) begin
          state_d = StRun;
          cnt_d   = '0;
          slot_d  = '0;
          shift_d = SampleData;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      StRun: begin
        if (cnt_q == LastCnt) begin
          cnt_d = '0;
          if (slot_q == 5'd31) begin
            slot_d = '0;
            if (Enable) begin
              // Back-to-back frame: capture the word requested at slot 16.
              shift_d = SampleData;
            end else begin
              state_d = StIdle;
              shift_d = '0;
            end
          end else begin
            slot_d  = slot_q + 5'd1;
            shift_d = {shift_q[30:0], 1'b0};
            // Request the next word as the right channel starts, if still running.
            req_d   = (slot_q == 5'd15) && Enable;
          end
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are derived from next-state values so the registers line up with the state.
    run_d   = (state_d == StRun);
    bclk_d  = run_d && (cnt_d >= HalfCnt);
    sdata_d = run_d && shift_d[31];
`ifdef I2S_DELAY_EN
    lrclk_d = run_d && (slot_d >= 5'd15) && (slot_d <= 5'd30);
`else
    lrclk_d = run_d && slot_d[4];
`endif
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge MasterCLK) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      slot_q  <= '0;
      shift_q <= '0;
      req_q   <= 1'b0;
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      req_q   <= req_d;
      bclk_q  <= bclk_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      busy_q  <= busy_d;
    end
  end

  assign SampleRequest = req_q;
  assign BCLK          = bclk_q;
  assign LRCLK         = lrclk_q;
  assign SDATA         = sdata_q;
  assign Busy          = busy_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter. Stimulus pushes expected serial bits and request times into
// queues; a monitor pops them on every BCLK rise / SampleRequest pulse and compares.

module tb_i2s_transmitter;

`ifdef I2S_DELAY_EN
  localparam int CD = 3;
`else
  localparam int CD = 2;
`endif

  logic        clk = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [31:0] SampleData;
  logic        SampleRequest, BCLK, LRCLK, SDATA, Busy;
  logic [4:0]  outs;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic       lr;
    logic       sd;
    logic [4:0] slot;
  } bit_t;

  bit_t exp_bits[$];
  int   exp_req[$];

  i2s_transmitter #(
    .CLK_DIV(CD)
  ) dut (
    .MasterCLK    (clk),
    .Reset        (Reset),
    .Enable       (Enable),
    .SampleData   (SampleData),
    .SampleRequest(SampleRequest),
    .BCLK         (BCLK),
    .LRCLK        (LRCLK),
    .SDATA        (SDATA),
    .Busy         (Busy)
  );

  assign outs = {SampleRequest, BCLK, LRCLK, SDATA, Busy};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic exp_lr(input int s);
`ifdef I2S_DELAY_EN
    return (s >= 15) && (s <= 30);
`else
    return s >= 16;
`endif
  endfunction

  task automatic push_frame(input logic [31:0] w);
    for (int s = 0; s < 32; s++) begin
      bit_t b;
      b.slot = 5'(s);
      b.sd   = w[31-s];
      b.lr   = exp_lr(s);
      exp_bits.push_back(b);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // PRIME: request pulse in the first cycle, then BCLK/LRCLK/SDATA low with Busy high.
  task automatic prime_check(input int t);
    for (int i = 0; i < 2 * CD; i++) begin
      wait_cyc(t + i);
      check("prime_outs", int'(outs), (i == 0) ? 5'b10001 : 5'b00001);
    end
  endtask

  // Monitor: DAC-style sampling on BCLK rise, BCLK high-time, request timing.
  initial begin
    bit   bclk_prev = 1'b0;
    bit   rise_valid = 1'b0;
    int   rise_t = 0;
    bit_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (BCLK && !bclk_prev) begin
          rise_t     = cyc;
          rise_valid = 1'b1;
          if (exp_bits.size() == 0) begin
            check("unexpected_bit", 1, 0);
          end else begin
            e = exp_bits.pop_front();
            check($sformatf("bit_slot%0d", e.slot), int'({LRCLK, SDATA}), int'({e.lr, e.sd}));
          end
        end
        if (!BCLK && bclk_prev && rise_valid) begin
          check("bclk_high_time", cyc - rise_t, CD);
        end
        if (SampleRequest) begin
          if (exp_req.size() == 0) check("unexpected_req", cyc, -1);
          else check("req_time", cyc, exp_req.pop_front());
        end
      end else begin
        rise_valid = 1'b0;
      end
      bclk_prev = BCLK;
    end
  end

  initial begin
    int t0;
    int t1;
    int t2;
    int n;
    Reset      = 1'b1;
    Enable     = 1'b0;
    SampleData = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", int'(outs), 0);
    Reset = 1'b0;

    // Idle with Enable low: nothing moves.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_outs", int'(outs), 0);
    end

    // Continuous run of three frames, Enable dropped in slot 5 of the third.
    SampleData = 32'hA5A5_0F0F;
    push_frame(32'hA5A5_0F0F);
    t0 = cyc + 1;
    exp_req.push_back(t0);
    exp_req.push_back(t0 + 34 * CD);
    exp_req.push_back(t0 + 98 * CD);
    mon_en = 1'b1;
    Enable = 1'b1;
    prime_check(t0);
    wait_cyc(t0 + 34 * CD);
    SampleData = 32'h8000_7FFF;
    push_frame(32'h8000_7FFF);
    wait_cyc(t0 + 98 * CD);
    SampleData = 32'h1234_C3C3;
    push_frame(32'h1234_C3C3);
    wait_cyc(t0 + 141 * CD);
    Enable = 1'b0;
    wait_cyc(t0 + 194 * CD - 1);
    check("busy_last_slot", int'(Busy), 1);
    wait_cyc(t0 + 194 * CD);
    check("idle_after_frame", int'(outs), 0);
    wait_cyc(t0 + 194 * CD + 20);
    check("bits_left", exp_bits.size(), 0);
    check("reqs_left", exp_req.size(), 0);

    // Reset mid-slot 20 with Enable held high: abort, Reset wins, then a fresh PRIME.
    mon_en     = 1'b0;
    SampleData = 32'hDEAD_BEEF;
    t1         = cyc + 1;
    Enable     = 1'b1;
    wait_cyc(t1 + 42 * CD + 1);
    Reset = 1'b1;
    n     = cyc;
    wait_cyc(n + 1);
    check("reset_abort", int'(outs), 0);
    wait_cyc(n + 2);
    check("reset_wins", int'(outs), 0);
    exp_bits.delete();
    exp_req.delete();
    SampleData = 32'hFFFF_0000;
    push_frame(32'hFFFF_0000);
    t2 = cyc + 1;
    exp_req.push_back(t2);
    mon_en = 1'b1;
    Reset  = 1'b0;
    prime_check(t2);
    wait_cyc(t2 + 6 * CD);
    Enable = 1'b0;
    wait_cyc(t2 + 66 * CD - 1);
    check("busy_last_slot2", int'(Busy), 1);
    wait_cyc(t2 + 66 * CD);
    check("idle_after_frame2", int'(outs), 0);
    wait_cyc(t2 + 66 * CD + 20);
    check("bits_left2", exp_bits.size(), 0);
    check("reqs_left2", exp_req.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
